// File: rtl/cr_prefix_fe_blk_ctlr_if.sv
// Inbound beat stream and block-buffer outputs of the prefix front-end block controller.
// The controller uses the slave modport; the upstream extractor / testbench uses master.
interface cr_prefix_fe_blk_ctlr_if #(
  parameter int DATA_W  = 64,
  parameter int NUM_BLK = 4,
  parameter int SEL_W   = (NUM_BLK > 2) ? $clog2(NUM_BLK) : 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W/8-1:0]   in_vbytes;
  logic                  in_eot;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [DATA_W/8-1:0]   out_vbytes;
  logic [SEL_W-1:0]      blk_sel;
  logic [NUM_BLK-1:0]    blk_wr;
  logic                  eodb;
  logic                  ovf;
  logic [15:0]           flush_cnt;

  modport master (
    output in_valid, in_data, in_vbytes, in_eot,
    input  in_ready,
    input  out_valid, out_data, out_vbytes, blk_sel, blk_wr, eodb, ovf, flush_cnt
  );

  modport slave (
    input  in_valid, in_data, in_vbytes, in_eot,
    output in_ready,
    output out_valid, out_data, out_vbytes, blk_sel, blk_wr, eodb, ovf, flush_cnt
  );
endinterface

// File: rtl/cr_prefix_fe_blk_ctlr.sv
// Prefix front-end block controller: slices frames into NUM_BLK blocks of BLK_BEATS beats.
// Optional flushed-frame counter enabled by defining CR_PREFIX_FE_FLUSH_CNT_EN.
module cr_prefix_fe_blk_ctlr #(
  parameter int DATA_W    = 64,
  parameter int NUM_BLK   = 4,
  parameter int BLK_BEATS = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cr_prefix_fe_blk_ctlr_if.slave bus
);
  localparam int SEL_W = (NUM_BLK > 2) ? $clog2(NUM_BLK) : 1;
  localparam int BC_W  = $clog2(BLK_BEATS + 1);
  localparam int VB_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, DATA, SW_BLK, FLUSH} state_t;

  state_t             state;
  logic [BC_W-1:0]    beat_ctr;
  logic [SEL_W-1:0]   sel;
  logic               term_eot;

  logic               vld_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [VB_W-1:0]    vbytes_p1;
  logic [SEL_W-1:0]   sel_p1;
  logic [NUM_BLK-1:0] blk_wr_p1;
  logic               eodb_p1;
  logic               ovf_p1;
  logic [15:0]        flush_cnt_p1;

  logic accept;
  logic blk_full;
  logic last_blk;
  logic enter_flush;

  // An eot close commits this block and every later one, so the buffers see a whole frame.
  function automatic logic [NUM_BLK-1:0] blk_mask(input logic [SEL_W-1:0] s, input logic cumulative);
    logic [NUM_BLK-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_BLK; k++)
      m[k] = cumulative ? (k >= int'(s)) : (k == int'(s));
    return m;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus.in_ready = (state != SW_BLK);
  assign accept       = bus.in_valid && bus.in_ready;
  assign blk_full     = (beat_ctr == BC_W'(BLK_BEATS - 1));
  assign last_blk     = (sel == SEL_W'(NUM_BLK - 1));
  assign enter_flush  = (state == SW_BLK) && !term_eot && last_blk;

  // Stage p1: registered beat forwarding and block-boundary strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_ctr  <= '0;
      sel       <= '0;
      term_eot  <= 1'b0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      vbytes_p1 <= '0;
      sel_p1    <= '0;
      blk_wr_p1 <= '0;
      eodb_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      blk_wr_p1 <= '0;
      eodb_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            vld_p1    <= 1'b1;
            data_p1   <= bus.in_data;
            vbytes_p1 <= bus.in_vbytes;
            sel_p1    <= sel;
            beat_ctr  <= beat_ctr + BC_W'(1);
            if (bus.in_eot || blk_full) begin
              state    <= SW_BLK;
              term_eot <= bus.in_eot;
            end else begin
              state    <= DATA;
            end
          end
        end
        SW_BLK: begin
          eodb_p1   <= 1'b1;
          blk_wr_p1 <= blk_mask(sel, term_eot);
          beat_ctr  <= '0;
          if (term_eot) begin
            state <= IDLE;
            sel   <= '0;
          end else if (last_blk) begin
            state  <= FLUSH;
            ovf_p1 <= 1'b1;
          end else begin
            state <= DATA;
            sel   <= sel + SEL_W'(1);
          end
        end
        FLUSH: begin
          if (accept && bus.in_eot) begin
            state <= IDLE;
            sel   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CR_PREFIX_FE_FLUSH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flush_cnt_p1 <= '0;
    else if (enter_flush)
      flush_cnt_p1 <= sat_inc16(flush_cnt_p1);
  end
`else
  assign flush_cnt_p1 = 16'd0;
`endif

  assign bus.out_valid  = vld_p1;
  assign bus.out_data   = data_p1;
  assign bus.out_vbytes = vbytes_p1;
  assign bus.blk_sel    = sel_p1;
  assign bus.blk_wr     = blk_wr_p1;
  assign bus.eodb       = eodb_p1;
  assign bus.ovf        = ovf_p1;
  assign bus.flush_cnt  = flush_cnt_p1;
endmodule

// File: doc/cr_prefix_fe_blk_ctlr.md
# cr_prefix_fe_blk_ctlr

Parametrised prefix front-end block controller. It accepts the user inbound data-beat stream, slices each frame into up to NUM_BLK fixed-size blocks of BLK_BEATS beats each, and forwards beats with a block select. At each block boundary it issues per-block write strobes and an end-of-data-block pulse. Frames longer than NUM_BLK×BLK_BEATS beats are flushed to end-of-frame with no further writes. It sits between the inbound TLV/character extractor and the prefix block buffers, and generalises the fixed 4×1K front-end controller.

## Interface
Parameters:
- DATA_W, 64: beat data width in bits; must be a multiple of 8.
- NUM_BLK, 4: number of blocks per frame; must be at least 2.
- BLK_BEATS, 128: beats per block; must be at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  inbound beat valid.
- in_ready  out  1  controller accepts a beat. A beat transfers when in_valid & in_ready.
- in_data  in  DATA_W  beat data.
- in_vbytes  in  DATA_W/8  valid-byte mask.
- in_eot  in  1  last beat of the frame.
- out_valid  out  1  forwarded beat valid.
- out_data  out  DATA_W  forwarded data.
- out_vbytes  out  DATA_W/8  forwarded mask.
- blk_sel  out  SEL_W=max(1,$clog2(NUM_BLK))  block the forwarded beat belongs to.
- blk_wr  out  NUM_BLK  block-commit strobes, one-cycle pulse.
- eodb  out  1  end-of-data-block pulse.
- ovf  out  1  one-cycle pulse when a frame enters FLUSH.
- flush_cnt  out  16  number of flushed frames (see Configuration).

## Operation
States:
- IDLE
- DATA
- SW_BLK
- FLUSH

Counters:
- beat_ctr: width $clog2(BLK_BEATS+1).
- sel: width SEL_W.
- term_eot: records whether the current block was closed by in_eot.

Reset values: state=IDLE, beat_ctr=0, sel=0. All outputs are 0.

in_ready is 1 in IDLE, DATA and FLUSH, and 0 in SW_BLK.

IDLE and DATA:
- Each accepted beat is registered to out_data/out_vbytes, with out_valid=1 and blk_sel=sel.
- beat_ctr increments by 1.
- If the beat has in_eot=1, or beat_ctr==BLK_BEATS-1 before the increment, the next state is SW_BLK and term_eot is set to in_eot.
- IDLE moves to DATA on the first accepted beat that does not close a block.

SW_BLK (exactly 1 cycle):
- eodb=1.
- If term_eot=1, blk_wr[k]=1 for every k≥sel (cumulative commit). Otherwise only blk_wr[sel]=1.
- beat_ctr is cleared to 0.
- Next state:
  - term_eot=1: IDLE, with sel cleared to 0.
  - sel==NUM_BLK-1: FLUSH, with ovf=1.
  - otherwise: DATA, with sel incremented by 1.

FLUSH:
- Beats are accepted and dropped: out_valid=0, and blk_wr, eodb and sel are unchanged.
- An accepted beat with in_eot=1 returns to IDLE with sel=0.

out_valid, blk_wr, eodb and ovf are 0 in every cycle not listed above.

## Timing
Latency:
- in→out latency is 1 cycle, and all outputs are registered.
- blk_wr and eodb assert in the cycle after the closing beat appears on out_valid.
- A block therefore costs BLK_BEATS+1 cycles at full throughput.

Boundary cases:
- A block that closes at exactly BLK_BEATS beats and whose last beat also has in_eot=1 is treated as an eot close: cumulative blk_wr, then IDLE. No FLUSH occurs, even on the last block.
- A single-beat frame passes through IDLE → SW_BLK with blk_wr = all ones.
- Back-to-back frames: the beat following SW_BLK is accepted immediately. No idle cycle is needed.
- in_valid=0 mid-block: the controller holds state and counters with no timeout.
- Reset mid-frame returns the controller to IDLE. The partial block is never committed and flush_cnt is cleared.

## Configuration
Macro CR_PREFIX_FE_FLUSH_CNT_EN:
- Defined: flush_cnt increments on every ovf pulse and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: the counter logic is not compiled and flush_cnt is tied to 16'd0. ovf and FLUSH behaviour are unchanged.

## Test plan
All scenarios use the defaults NUM_BLK=4 and BLK_BEATS=128.
- 300-beat frame with eot on beat 300 → blocks 0, 1 and 2 forwarded with blk_sel 0, 1, 2. blk_wr pulses 4'b0001, then 4'b0010, then 4'b1100, with 3 eodb pulses and ovf=0.
- 1-beat frame with eot, vbytes=8'h0F → out_vbytes=8'h0F, blk_sel=0, a single cycle of blk_wr=4'b1111, eodb=1.
- 512-beat frame with eot on beat 512 → 4 eodb pulses, the last with blk_wr=4'b1000. No FLUSH.
- 600-beat frame → 512 beats forwarded and strobes 0001, 0010, 0100, 1000. ovf pulses once and 88 beats are dropped. The next frame starts at blk_sel=0 and flush_cnt=1 (macro defined) or 0 (undefined).
- Random in_valid gaps over a 256-beat frame → output beat order and values identical to the gapless run, and in_ready=0 only during SW_BLK cycles.
- rst_n asserted at beat 50 of block 1 → all outputs 0 and state IDLE. A new 10-beat frame yields blk_wr=4'b1111 with blk_sel=0.
